regs_wr_arbiter: RTL and testbench
==================================

# regs_wr_arbiter

Shares the single write port of the 32×32 register file (`Regs`: `L_S`, `Wt_addr`, `Wt_data`) between three writeback requesters: ALU, load unit and debug/scan. It sits between those units and `Regs`, and registers the selected write for one cycle before it reaches the file. It also provides read-bypass data for the in-flight write on both read ports, plus a saturating count of committed writes.

## Interface
Parameters:
- `DW`, default 32: data width.
- `AW`, default 5: register address width.
- `CW`, default 16: commit counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `freeze`  in  1  when 1, grant nothing this cycle.
- `req_valid`  in  3  per-requester write request. Bit 0 = ALU, bit 1 = load, bit 2 = debug.
- `req_addr`  in  3×AW  packed destination addresses. Requester i uses bits [i*AW +: AW].
- `req_data`  in  3×DW  packed write data. Requester i uses bits [i*DW +: DW].
- `req_ready`  out  3  one-hot grant; combinational.
- `L_S`  out  1  write enable to `Regs`; registered.
- `Wt_addr`  out  AW  write address to `Regs`; registered.
- `Wt_data`  out  DW  write data to `Regs`; registered.
- `R_addr_A`, `R_addr_B`  in  AW  the read addresses currently presented to `Regs`.
- `byp_hit_A`, `byp_hit_B`  out  1  the in-flight write targets that read address; combinational.
- `byp_data_A`, `byp_data_B`  out  DW  bypass data. Equals `Wt_data` when the corresponding hit is 1, else 0.
- `wr_count`  out  CW  committed-write counter; saturates at all ones.

## Operation
- **Handshake**
  - A transfer from requester i occurs when `req_valid[i] && req_ready[i]`.
  - At most one `req_ready` bit is set per cycle.
  - `req_ready` is 0 when `freeze` = 1 or when `req_valid` = 0.
  - A requester holds its valid, address and data stable until it is granted.
- **Arbitration**
  - Round-robin pointer `ptr` takes values 0..2.
  - Search order is ptr, ptr+1, ptr+2 (mod 3); the first valid requester wins.
  - After a grant to requester i, `ptr` ← (i+1) mod 3.
  - `ptr` is unchanged when there is no grant.
  - The pointer value 3 is unreachable. If it ever occurs, treat it as 0.
- **Output stage**
  - On each rising edge: `L_S` ← (grant && addr ≠ 0).
  - `Wt_addr`/`Wt_data` ← the granted requester's address and data.
  - Without a grant, `Wt_addr`/`Wt_data` hold their previous values and `L_S` ← 0.
- **Writes to r0**
  - Granted and consumed normally; requester ready = 1.
  - Never drive `L_S` = 1.
  - Not counted in `wr_count`.
- **Bypass**
  - `byp_hit_X` = `L_S` && (`Wt_addr` == `R_addr_X`) && (`R_addr_X` ≠ 0).
  - This covers the cycle in which `Regs` still returns the old value, before the write lands at the next edge.
- **`wr_count`**
  - Increments at the edge following every cycle in which `L_S` = 1.
  - Holds at 2^CW−1.
- **`freeze`**
  - Affects only new grants.
  - A write already registered still commits (`L_S` stays 1 for its cycle).

## Timing
- **Reset values** (while `rst` = 0, asynchronous): `L_S` = 0, `Wt_addr` = 0, `Wt_data` = 0, `ptr` = 0, `wr_count` = 0. Consequently `req_ready`, `byp_hit_*` and `byp_data_*` are 0 during reset.
- **Reset mid-operation**: an in-flight registered write is discarded; `L_S` falls immediately on assertion of reset.
- **Reset release**: first grant possible in the first cycle after `rst` rises, sampled at the next edge.
- **Latency**: a request granted in cycle t produces `L_S` = 1 in cycle t+1 for exactly one cycle. `Regs` writes at the end of cycle t+1.
- **Throughput**: one write per cycle, sustained with no bubbles, under continuous valid requests.
- **Simultaneous valid**: all three requesters valid for 3 consecutive cycles → one grant to each, in pointer order.
- **Timing paths**: `req_ready` depends only on `req_valid`, `freeze` and `ptr`; there is no path from `L_S` to `req_ready`.

## Test plan
- **Reset values**: `rst` = 0 with random inputs → all outputs 0. Release `rst`, then ALU writes addr 3, data 32'hA5A5A5A5 → `req_ready` = 3'b001 in the same cycle; next cycle `L_S` = 1, `Wt_addr` = 3, `Wt_data` = A5A5A5A5; `wr_count` = 1 afterwards.
- **Round-robin**: all three valid for 6 cycles (addrs 1/2/3, data 11/22/33) → grants 0,1,2,0,1,2. `Wt_addr` sequence 1,2,3,1,2,3 with `L_S` = 1 on all 6 cycles. With only load and debug valid from `ptr` = 0 → grant load first.
- **r0 write**: ALU write to addr 0, data FFFFFFFF → `req_ready[0]` = 1, `L_S` stays 0, `wr_count` unchanged.
- **Bypass**: ALU writes r4 = 12345678 with `R_addr_A` = 4 and `R_addr_B` = 5 → in the `L_S` cycle, `byp_hit_A` = 1 with `byp_data_A` = 12345678, and `byp_hit_B` = 0. With `R_addr_A` = 0 → no hit.
- **`freeze` and mid-flight reset**:
  - Grant at t, `freeze` = 1 at t+1 → `L_S` = 1 at t+1, no grants while frozen, `ptr` unchanged.
  - Pulse `rst` low during an `L_S` = 1 cycle → `L_S` drops asynchronously, `wr_count` = 0 and `ptr` = 0 after release.
- **Counter saturation** (CW = 4): commit 17 writes → `wr_count` = 15.

Source files
------------

// File: rtl/regs_wr_arbiter.sv
// regs_wr_arbiter: round-robin share of the register-file write port between
// ALU (0), load (1) and debug (2). The winning write is registered for one
// cycle before it reaches Regs. Read bypass for the in-flight write and a
// saturating commit counter are also provided.
module regs_wr_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic [2:0]      req_valid,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_data,
    output logic [2:0]      req_ready,
    output logic            L_S,
    output logic [AW-1:0]   Wt_addr,
    output logic [DW-1:0]   Wt_data,
    input  logic [AW-1:0]   R_addr_A,
    input  logic [AW-1:0]   R_addr_B,
    output logic            byp_hit_A,
    output logic            byp_hit_B,
    output logic [DW-1:0]   byp_data_A,
    output logic [DW-1:0]   byp_data_B,
    output logic [CW-1:0]   wr_count
);

    logic [1:0]    ptr;
    logic [1:0]    ptr_eff;
    logic [2:0]    scan;
    logic          gnt;
    logic [1:0]    gidx;
    logic [1:0]    ptr_nxt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // An illegal pointer value of 3 behaves as 0.
    assign ptr_eff = (ptr == 2'd3) ? 2'd0 : ptr;

    // Round-robin scan from ptr; only valid/freeze/ptr feed the grant.
    // The grant is also masked while reset is held so ready reads 0 then.
    always_comb begin
        gnt  = 1'b0;
        gidx = 2'd0;
        scan = 3'd0;
        for (int k = 0; k < 3; k++) begin
            scan = {1'b0, ptr_eff} + 3'(k);
            if (scan >= 3'd3) scan = scan - 3'd3;
            if (!gnt && req_valid[scan[1:0]]) begin
                gnt  = 1'b1;
                gidx = scan[1:0];
            end
        end
        if (!rst || freeze) gnt = 1'b0;
        req_ready = gnt ? (3'b001 << gidx) : 3'b000;
    end

    // Pick the winner's address/data and the pointer that follows it.
    always_comb begin
        case (gidx)
            2'd1:    begin sel_addr = req_addr[AW +: AW];   sel_data = req_data[DW +: DW];   end
            2'd2:    begin sel_addr = req_addr[2*AW +: AW]; sel_data = req_data[2*DW +: DW]; end
            default: begin sel_addr = req_addr[0 +: AW];    sel_data = req_data[0 +: DW];    end
        endcase
        ptr_nxt = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end

    // Pointer advances past the winner; holds without a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     ptr <= 2'd0;
        else if (gnt) ptr <= ptr_nxt;
    end

    // Output register: r0 writes are consumed but never enable the file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            L_S     <= 1'b0;
            Wt_addr <= '0;
            Wt_data <= '0;
        end else begin
            L_S <= gnt && (sel_addr != '0);
            if (gnt) begin
                Wt_addr <= sel_addr;
                Wt_data <= sel_data;
            end
        end
    end

    // Count committed writes, sticking at all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        wr_count <= '0;
        else if (L_S && (wr_count != '1)) wr_count <= wr_count + 1'b1;
    end

    // Forward the in-flight write while Regs still returns the old value.
    always_comb begin
        byp_hit_A  = L_S && (Wt_addr == R_addr_A) && (R_addr_A != '0);
        byp_hit_B  = L_S && (Wt_addr == R_addr_B) && (R_addr_B != '0);
        byp_data_A = byp_hit_A ? Wt_data : '0;
        byp_data_B = byp_hit_B ? Wt_data : '0;
    end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter; counter built narrow to reach saturation.
module tb_regs_wr_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            freeze;
    logic [2:0]      req_valid;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data;
    logic [2:0]      req_ready;
    logic            L_S;
    logic [AW-1:0]   Wt_addr;
    logic [DW-1:0]   Wt_data;
    logic [AW-1:0]   R_addr_A;
    logic [AW-1:0]   R_addr_B;
    logic            byp_hit_A;
    logic            byp_hit_B;
    logic [DW-1:0]   byp_data_A;
    logic [DW-1:0]   byp_data_B;
    logic [CW-1:0]   wr_count;

    int n_chk = 0;
    int n_err = 0;

    regs_wr_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
        .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
        .byp_hit_A(byp_hit_A), .byp_hit_B(byp_hit_B),
        .byp_data_A(byp_data_A), .byp_data_B(byp_data_B),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // advance one edge, settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with random inputs
        rst       = 1'b0;
        freeze    = 1'b0;
        req_valid = 3'($urandom_range(1, 7));
        req_addr  = 15'($urandom);
        req_data  = {$urandom, $urandom, $urandom};
        R_addr_A  = 5'($urandom);
        R_addr_B  = 5'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_ls", 64'(L_S), 64'd0);
        chk("rst_waddr", 64'(Wt_addr), 64'd0);
        chk("rst_wdata", 64'(Wt_data), 64'd0);
        chk("rst_hitA", 64'(byp_hit_A), 64'd0);
        chk("rst_hitB", 64'(byp_hit_B), 64'd0);
        chk("rst_bypA", 64'(byp_data_A), 64'd0);
        chk("rst_cnt", 64'(wr_count), 64'd0);

        req_valid = 3'b000;
        R_addr_A  = 5'd0;
        R_addr_B  = 5'd0;
        #3 rst = 1'b1;
        tick();

        // first write after reset: ALU r3
        set_req(0, 5'd3, 32'hA5A5A5A5);
        req_valid = 3'b001;
        #1 chk("alu_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        chk("alu_ls", 64'(L_S), 64'd1);
        chk("alu_waddr", 64'(Wt_addr), 64'd3);
        chk("alu_wdata", 64'(Wt_data), 64'hA5A5A5A5);
        tick();
        chk("alu_ls_one", 64'(L_S), 64'd0);
        chk("alu_cnt", 64'(wr_count), 64'd1);

        // debug write returns ptr to 0 (ptr was 1 -> scan 1,2 -> debug)
        set_req(2, 5'd7, 32'h77);
        req_valid = 3'b100;
        #1 chk("dbg_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        tick();
        chk("dbg_cnt", 64'(wr_count), 64'd2);

        // round robin: all valid 6 cycles
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
            tick();
            chk("rr_ls", 64'(L_S), 64'd1);
            chk("rr_waddr", 64'(Wt_addr), 64'((k % 3) + 1));
            chk("rr_wdata", 64'(Wt_data), 64'(((k % 3) + 1) * 32'h11));
        end
        req_valid = 3'b000;
        tick();
        chk("rr_ls_end", 64'(L_S), 64'd0);
        chk("rr_cnt", 64'(wr_count), 64'd8);

        // load and debug from ptr 0 -> load first
        req_valid = 3'b110;
        #1 chk("ld_first", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        tick();
        chk("ld_cnt", 64'(wr_count), 64'd9);

        // r0 write (ptr 2: scan 2,0 -> ALU)
        set_req(0, 5'd0, 32'hFFFFFFFF);
        req_valid = 3'b001;
        #1 chk("r0_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        chk("r0_ls", 64'(L_S), 64'd0);
        chk("r0_wdata", 64'(Wt_data), 64'hFFFFFFFF);
        tick();
        chk("r0_cnt", 64'(wr_count), 64'd9);

        // bypass: ALU r4
        set_req(0, 5'd4, 32'h12345678);
        R_addr_A  = 5'd4;
        R_addr_B  = 5'd5;
        req_valid = 3'b001;
        #1 chk("byp_ready", 64'(req_ready), 64'b001);
        chk("byp_pre_hit", 64'(byp_hit_A), 64'd0);
        tick();
        req_valid = 3'b000;
        chk("byp_ls", 64'(L_S), 64'd1);
        chk("byp_hitA", 64'(byp_hit_A), 64'd1);
        chk("byp_dataA", 64'(byp_data_A), 64'h12345678);
        chk("byp_hitB", 64'(byp_hit_B), 64'd0);
        chk("byp_dataB", 64'(byp_data_B), 64'd0);
        R_addr_A = 5'd0;
        #1 chk("byp_r0_hit", 64'(byp_hit_A), 64'd0);
        chk("byp_r0_data", 64'(byp_data_A), 64'd0);
        tick();
        chk("byp_cnt", 64'(wr_count), 64'd10);

        // freeze after a grant (ptr 1 -> ALU)
        set_req(0, 5'd6, 32'h66);
        set_req(1, 5'd2, 32'h22);
        req_valid = 3'b001;
        #1 chk("frz_grant", 64'(req_ready), 64'b001);
        tick();
        freeze    = 1'b1;
        req_valid = 3'b111;
        #1 chk("frz_ls", 64'(L_S), 64'd1);
        chk("frz_ready0", 64'(req_ready), 64'd0);
        tick();
        chk("frz_ls_off", 64'(L_S), 64'd0);
        chk("frz_ready1", 64'(req_ready), 64'd0);
        chk("frz_cnt", 64'(wr_count), 64'd11);
        freeze = 1'b0;
        #1 chk("frz_ptr", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        tick();
        chk("frz_cnt2", 64'(wr_count), 64'd12);

        // mid-flight reset (ptr 2 -> ALU wins, ptr would become 1)
        set_req(0, 5'd9, 32'h99);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        chk("mid_ls", 64'(L_S), 64'd1);
        #1 rst = 1'b0;
        #1 chk("mid_ls_async", 64'(L_S), 64'd0);
        chk("mid_cnt", 64'(wr_count), 64'd0);
        chk("mid_waddr", 64'(Wt_addr), 64'd0);
        #1 rst = 1'b1;
        tick();
        chk("mid_cnt_rel", 64'(wr_count), 64'd0);

        // ptr back at 0: ALU beats debug; then saturate with 17 commits
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        req_valid = 3'b101;
        #1 chk("mid_ptr", 64'(req_ready), 64'b001);
        req_valid = 3'b111;
        for (int k = 0; k < 17; k++) tick();
        req_valid = 3'b000;
        chk("sat_ls", 64'(L_S), 64'd1);
        tick();
        chk("sat_cnt", 64'(wr_count), 64'd15);
        tick();
        chk("sat_hold", 64'(wr_count), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
